safe_sdram: RTL and testbench
=============================

Name: safe_sdram

Overview:
- Timing-safe command layer between the EasySDRAM scheduler and the DE1 IS42S16320 SDRAM pins.
- Accepts one abstract command per cycle and enforces every JEDEC inter-command delay.
- Any command that would violate timing or state is replaced by NOOP.
- Drives the SDRAM pins and returns read data tagged with its full 25-bit address.

Parameters:
- CAS_LAT, 2: CAS latency programmed into the mode register.
- READ_LATENCY, 4: cycles from a READ/READA presented on `command` to `readValid`.

Ports:
- clk  in  1  system clock, 133 MHz max
- rst_n  in  1  asynchronous active-low reset
- command  in  CommandEnum  NOOP, PRECHARGE_ALL, SET_MODE_REG, AREFRESH, ACTIVATE, READ, READA, WRITE, WRITEA
- addr  in  13  ACTIVATE: row; READ/WRITE: column in [9:0]
- bankSel  in  2  bank for ACTIVATE
- writeMask  in  2  byte enables; [1]=upper byte, [0]=lower byte
- wdata  in  16  write data
- commandReady  out  1  a new command is accepted this cycle
- prechargeReady  out  1  PRECHARGE_ALL is legal now
- writeReady  out  1  WRITE/WRITEA is legal now (bus free)
- rowOpen  out  1  a row is currently active
- readValid  out  1  single-cycle read-data strobe
- raddr  out  25  {bank,row[12:0],col[9:0]}; bits [24:10] always hold the currently/last opened row
- rdata  out  16  read data
- DRAM_DQ  inout  16  data bus
- DRAM_ADDR  out  13  address pins
- DRAM_BA  out  2  bank address pins
- DRAM_CAS_N, DRAM_CKE, DRAM_CLK, DRAM_CS_N, DRAM_LDQM, DRAM_RAS_N, DRAM_UDQM, DRAM_WE_N  out  1 each  SDRAM control pins

Behaviour:
Reset values:
- Pins show NOP (CS_N,RAS_N,CAS_N,WE_N = 0,1,1,1); CKE=1; DQ hi-Z; DQM=0.
- rowOpen=0, commandReady=1, prechargeReady=1, writeReady=1, readValid=0, raddr=0, rdata=0.
- Any pending read returns are dropped.

Clocking and command timing:
- DRAM_CLK = ~clk.
- Pin outputs are registered: a command accepted at edge N appears on the pins for cycle N+1.

Legality (otherwise the command becomes NOOP):
- All commands require commandReady.
- ACTIVATE, AREFRESH, SET_MODE_REG additionally require ~rowOpen.
- READ/READA additionally require rowOpen.
- WRITE/WRITEA additionally require rowOpen & writeReady.
- PRECHARGE_ALL additionally requires prechargeReady.

Pin encodings (CS,RAS,CAS,WE):
- ACT 0011: BA=bankSel, ADDR=addr; latch raddr[24:10]={bankSel,addr}; rowOpen<=1.
- READ 0101 / WRITE 0100: BA=latched bank, ADDR={2'b0,A10,addr[9:0]}; A10=1 for READA/WRITEA, which also clear rowOpen.
- PRE 0010 with A10=1; clears rowOpen.
- REF 0001.
- MRS 0000: BA=0, ADDR = burst length 1, sequential, CL=CAS_LAT, single-location writes (13'h020 for CL=2).
- WRITE data: DQ driven with wdata in the same pin cycle; UDQM=~writeMask[1], LDQM=~writeMask[0].
- DQ is hi-Z in all non-write cycles; DQM=0 outside writes.

Busy windows (commandReady low, counted from the accept cycle):
- ACTIVATE: T_RCD
- PRECHARGE_ALL: T_RP
- AREFRESH: T_RC
- SET_MODE_REG: T_MRD
- READA: T_RP+1
- WRITEA: T_DPL+T_RP
- READ/WRITE: 0

Status outputs:
- prechargeReady = ~rowOpen | (≥T_RAS cycles since ACTIVATE and ≥T_DPL cycles since last WRITE).
- writeReady is low for CAS_LAT+1 cycles after a READ (bus turnaround).
- Read return: exactly READ_LATENCY cycles after the accept, readValid=1 for one cycle; raddr={open row, col}; rdata=DQ captured that cycle. Back-to-back READs give back-to-back readValid.
- Reset mid-operation aborts immediately; the upper layer redoes boot.

Decomposition:
- Package SDRAM timing (cycles @133 MHz): T_RP=2, T_RCD=2, T_RC=8, T_RAS=5, T_DPL=2, T_MRD=2, mode word.
- CommandEnumPackage holds CommandEnum.
- No sub-module; one counter per constraint plus a read-return shift pipeline.

Test Plan:
- Reset, then PRECHARGE_ALL → pins 0010 with A10=1; commandReady low 2 cycles. Then SET_MODE_REG → pins 0000, ADDR=13'h020.
- AREFRESH → commandReady low 8 cycles; AREFRESH re-presented during that window produces NOP on the pins.
- ACTIVATE bank 1, row 5 → raddr[24:10]=15'h2005, rowOpen=1. WRITE col 3 with wdata 16'hDEAD and mask 2'b10 → DQ=DEAD, UDQM=0, LDQM=1.
- Immediately after the WRITE, PRECHARGE_ALL → suppressed until prechargeReady (T_RAS and T_DPL met).
- READ col 3 → readValid 4 cycles later with raddr={2'b01,13'd5,10'd3} and rdata = modelled DQ 16'hDEAD; a WRITE within 3 cycles of the READ is suppressed.
- READ with no row open, and ACTIVATE with a row open → both become NOP; rowOpen and raddr unchanged.

Source files
------------

// File: rtl/safe_sdram_pkg.sv
// Command set, IS42S16320 timing (cycles at 133 MHz) and pin encodings for safe_sdram.
// Pure declarations; no logic.
// Shared by the command layer and its bench.
package safe_sdram_pkg;

  typedef enum logic [3:0] {
    NOOP, PRECHARGE_ALL, SET_MODE_REG, AREFRESH, ACTIVATE, READ, READA, WRITE, WRITEA
  } CommandEnum;

  localparam int T_RP  = 2;
  localparam int T_RCD = 2;
  localparam int T_RC  = 8;
  localparam int T_RAS = 5;
  localparam int T_DPL = 2;
  localparam int T_MRD = 2;

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] PIN_NOP   = 4'b0111;
  localparam logic [3:0] PIN_ACT   = 4'b0011;
  localparam logic [3:0] PIN_READ  = 4'b0101;
  localparam logic [3:0] PIN_WRITE = 4'b0100;
  localparam logic [3:0] PIN_PRE   = 4'b0010;
  localparam logic [3:0] PIN_REF   = 4'b0001;
  localparam logic [3:0] PIN_MRS   = 4'b0000;

  // Burst length 1, sequential, CAS latency in A[6:4]; with BL=1 every write is single-location.
  function automatic logic [12:0] mode_word(input int cas_lat);
    logic [2:0] cl;
    cl = 3'(cas_lat);
    return {6'b000000, cl, 4'b0000};
  endfunction

endpackage

// File: rtl/safe_sdram.sv
// Timing-safe SDRAM command layer: filters illegal/early commands to NOP and drives registered pins.
// Latency: accepted command on pins next cycle; read data returned READ_LATENCY cycles after accept.
// Backpressure: commandReady/prechargeReady/writeReady advertise legality; rejected commands become NOP.
module safe_sdram
  import safe_sdram_pkg::*;
#(
  parameter int CAS_LAT      = 2,
  parameter int READ_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  CommandEnum  command,
  input  logic [12:0] addr,
  input  logic [1:0]  bankSel,
  input  logic [1:0]  writeMask,
  input  logic [15:0] wdata,
  output logic        commandReady,
  output logic        prechargeReady,
  output logic        writeReady,
  output logic        rowOpen,
  output logic        readValid,
  output logic [24:0] raddr,
  output logic [15:0] rdata,
  inout  wire  [15:0] DRAM_DQ,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic        DRAM_CAS_N,
  output logic        DRAM_CKE,
  output logic        DRAM_CLK,
  output logic        DRAM_CS_N,
  output logic        DRAM_LDQM,
  output logic        DRAM_RAS_N,
  output logic        DRAM_UDQM,
  output logic        DRAM_WE_N
);

  // Read-return stages ahead of the output register.
  localparam int RP = READ_LATENCY - 1;

  typedef logic [3:0] cnt_t;

  function automatic cnt_t dec(input cnt_t c);
    return (c == '0) ? '0 : c - 4'd1;
  endfunction

  CommandEnum  eff;
  logic        legal, rd_acc;
  cnt_t        busy_q, busy_d, ras_q, ras_d, dpl_q, dpl_d, turn_q, turn_d;
  logic        row_open_q, row_open_d;
  logic [14:0] row_q, row_d;
  logic [9:0]  col_q;
  logic [3:0]  pin_q, pin_d;
  logic [1:0]  ba_q, ba_d;
  logic [12:0] addr_q, addr_d;
  logic        udqm_q, udqm_d, ldqm_q, ldqm_d, dq_oe_q, dq_oe_d;
  logic [15:0] dq_q, dq_d;
  logic [RP-1:0] rd_vld_q;
  logic [9:0]  rd_col_q [RP];
  logic        rvld_q;
  logic [15:0] rdata_q;

  assign commandReady   = (busy_q == '0);
  // ras/dpl count down to the first cycle a precharge may be accepted.
  assign prechargeReady = ~row_open_q | ((ras_q == '0) & (dpl_q == '0));
  assign writeReady     = (turn_q == '0);
  assign rowOpen        = row_open_q;
  assign readValid      = rvld_q;
  assign raddr          = {row_q, col_q};
  assign rdata          = rdata_q;

  assign DRAM_CLK = ~clk;
  assign DRAM_CKE = 1'b1;
  assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = pin_q;
  assign DRAM_BA   = ba_q;
  assign DRAM_ADDR = addr_q;
  assign DRAM_UDQM = udqm_q;
  assign DRAM_LDQM = ldqm_q;
  assign DRAM_DQ   = dq_oe_q ? dq_q : 16'hzzzz;

  // Legality filter: anything not allowed in the current state is turned into NOOP.
  always_comb begin
    legal = 1'b0;
    case (command)
      ACTIVATE, AREFRESH, SET_MODE_REG: legal = ~row_open_q;
      READ, READA:                      legal = row_open_q;
      WRITE, WRITEA:                    legal = row_open_q & writeReady;
      PRECHARGE_ALL:                    legal = prechargeReady;
      default:                          legal = 1'b0;
    endcase
    eff = (commandReady && legal) ? command : NOOP;
  end

  // Pin encoding and timing-counter loads for the effective command.
  always_comb begin
    busy_d     = dec(busy_q);
    ras_d      = dec(ras_q);
    dpl_d      = dec(dpl_q);
    turn_d     = dec(turn_q);
    row_open_d = row_open_q;
    row_d      = row_q;
    pin_d      = PIN_NOP;
    ba_d       = 2'b00;
    addr_d     = 13'h0;
    udqm_d     = 1'b0;
    ldqm_d     = 1'b0;
    dq_oe_d    = 1'b0;
    dq_d       = 16'h0;
    rd_acc     = 1'b0;
    case (eff)
      PRECHARGE_ALL: begin
        pin_d      = PIN_PRE;
        addr_d[10] = 1'b1;
        row_open_d = 1'b0;
        busy_d     = 4'(T_RP);
      end
      SET_MODE_REG: begin
        pin_d  = PIN_MRS;
        addr_d = mode_word(CAS_LAT);
        busy_d = 4'(T_MRD);
      end
      AREFRESH: begin
        pin_d  = PIN_REF;
        busy_d = 4'(T_RC);
      end
      ACTIVATE: begin
        pin_d      = PIN_ACT;
        ba_d       = bankSel;
        addr_d     = addr;
        row_d      = {bankSel, addr};
        row_open_d = 1'b1;
        busy_d     = 4'(T_RCD);
        ras_d      = 4'(T_RAS - 1);
      end
      READ, READA: begin
        pin_d  = PIN_READ;
        ba_d   = row_q[14:13];
        addr_d = {2'b00, eff == READA, addr[9:0]};
        turn_d = 4'(CAS_LAT + 1);
        rd_acc = 1'b1;
        if (eff == READA) begin
          row_open_d = 1'b0;
          busy_d     = 4'(T_RP + 1);
        end
      end
      WRITE, WRITEA: begin
        pin_d   = PIN_WRITE;
        ba_d    = row_q[14:13];
        addr_d  = {2'b00, eff == WRITEA, addr[9:0]};
        dq_oe_d = 1'b1;
        dq_d    = wdata;
        udqm_d  = ~writeMask[1];
        ldqm_d  = ~writeMask[0];
        dpl_d   = 4'(T_DPL - 1);
        if (eff == WRITEA) begin
          row_open_d = 1'b0;
          busy_d     = 4'(T_DPL + T_RP);
        end
      end
      default: ;
    endcase
  end

  // State, pin registers and the read-return pipeline; reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      ras_q      <= '0;
      dpl_q      <= '0;
      turn_q     <= '0;
      row_open_q <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      pin_q      <= PIN_NOP;
      ba_q       <= '0;
      addr_q     <= '0;
      udqm_q     <= 1'b0;
      ldqm_q     <= 1'b0;
      dq_oe_q    <= 1'b0;
      dq_q       <= '0;
      rd_vld_q   <= '0;
      for (int i = 0; i < RP; i++) rd_col_q[i] <= '0;
      rvld_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      busy_q     <= busy_d;
      ras_q      <= ras_d;
      dpl_q      <= dpl_d;
      turn_q     <= turn_d;
      row_open_q <= row_open_d;
      row_q      <= row_d;
      pin_q      <= pin_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
      udqm_q     <= udqm_d;
      ldqm_q     <= ldqm_d;
      dq_oe_q    <= dq_oe_d;
      dq_q       <= dq_d;
      rd_vld_q[0] <= rd_acc;
      rd_col_q[0] <= addr[9:0];
      for (int i = 1; i < RP; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_col_q[i] <= rd_col_q[i-1];
      end
      rvld_q <= rd_vld_q[RP-1];
      if (rd_vld_q[RP-1]) begin
        col_q   <= rd_col_q[RP-1];
        rdata_q <= DRAM_DQ;
      end
    end
  end

endmodule

// File: tb/tb_safe_sdram.sv
// Bench for safe_sdram: a small SDRAM pin model drives read data with CAS latency 2,
// and a scoreboard matches every read return (address, data, cycle) against expectations.
module tb_safe_sdram;
  import safe_sdram_pkg::*;

  localparam int CL = 2;
  localparam int RL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  CommandEnum  command;
  logic [12:0] addr;
  logic [1:0]  bankSel, writeMask;
  logic [15:0] wdata;
  logic        commandReady, prechargeReady, writeReady, rowOpen, readValid;
  logic [24:0] raddr;
  logic [15:0] rdata;
  wire  [15:0] DRAM_DQ;
  logic [12:0] DRAM_ADDR;
  logic [1:0]  DRAM_BA;
  logic DRAM_CAS_N, DRAM_CKE, DRAM_CLK, DRAM_CS_N, DRAM_LDQM, DRAM_RAS_N, DRAM_UDQM, DRAM_WE_N;

  logic        tb_oe;
  logic [15:0] tb_dq;
  assign DRAM_DQ = tb_oe ? tb_dq : 16'hzzzz;

  safe_sdram #(.CAS_LAT(CL), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .command(command), .addr(addr), .bankSel(bankSel),
    .writeMask(writeMask), .wdata(wdata), .commandReady(commandReady),
    .prechargeReady(prechargeReady), .writeReady(writeReady), .rowOpen(rowOpen),
    .readValid(readValid), .raddr(raddr), .rdata(rdata), .DRAM_DQ(DRAM_DQ),
    .DRAM_ADDR(DRAM_ADDR), .DRAM_BA(DRAM_BA), .DRAM_CAS_N(DRAM_CAS_N), .DRAM_CKE(DRAM_CKE),
    .DRAM_CLK(DRAM_CLK), .DRAM_CS_N(DRAM_CS_N), .DRAM_LDQM(DRAM_LDQM), .DRAM_RAS_N(DRAM_RAS_N),
    .DRAM_UDQM(DRAM_UDQM), .DRAM_WE_N(DRAM_WE_N)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [24:0] a; logic [15:0] d; int c; } exp_t;
  exp_t sbq[$];
  logic [15:0] written [logic [24:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] pins();
    return {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};
  endfunction

  // SDRAM model: stores written words, drives read data two cycles after READ appears on pins.
  logic [12:0] mdl_row [4];
  logic [15:0] mdl_mem [logic [24:0]];
  logic        s0, s1;
  logic [15:0] d0, d1;
  initial begin
    tb_oe = 1'b0; tb_dq = 16'h0; s0 = 1'b0; s1 = 1'b0; d0 = 16'h0; d1 = 16'h0;
    for (int i = 0; i < 4; i++) mdl_row[i] = 13'h0;
  end
  always @(negedge clk) begin
    logic [24:0] k;
    tb_oe = s1; tb_dq = d1; s1 = s0; d1 = d0; s0 = 1'b0;
    k = {DRAM_BA, mdl_row[DRAM_BA], DRAM_ADDR[9:0]};
    case (pins())
      4'b0011: mdl_row[DRAM_BA] = DRAM_ADDR;
      4'b0100: mdl_mem[k] = DRAM_DQ;
      4'b0101: begin s0 = 1'b1; d0 = mdl_mem.exists(k) ? mdl_mem[k] : 16'h0; end
      default: ;
    endcase
  end

  // Scoreboard: every readValid must match the oldest expected return exactly.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && readValid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read got raddr=%h rdata=%h, expected no return", raddr, rdata);
      end else begin
        e = sbq.pop_front();
        if (raddr !== e.a || rdata !== e.d || cyc !== e.c) begin
          errors++;
          $display("FAIL read_return got raddr=%h rdata=%h cyc=%0d, expected raddr=%h rdata=%h cyc=%0d",
                   raddr, rdata, cyc, e.a, e.d, e.c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents one command for a single cycle; acc is the index of the accepting edge.
  task automatic send(input CommandEnum c, input logic [12:0] a, input logic [1:0] b,
                      input logic [1:0] m, input logic [15:0] d, output int acc);
    command = c; addr = a; bankSel = b; writeMask = m; wdata = d;
    tick();
    acc = cyc;
    command = NOOP;
  endtask

  // Called at the negedge of the first cycle after an accept; counts commandReady-low cycles.
  task automatic wait_ready(output int n);
    n = 0;
    while (!commandReady && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  // A read accepted at edge acc returns in the cycle beginning at edge acc+RL-1.
  task automatic expect_read(input logic [24:0] a, input int acc);
    sbq.push_back('{a: a, d: written[a], c: acc + RL - 1});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; command = NOOP; addr = '0; bankSel = '0; writeMask = 2'b11; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (pins() !== 4'b0111 || DRAM_CKE !== 1'b1) begin errors++;
      $display("FAIL reset_pins got %b cke=%b, expected 0111 cke=1", pins(), DRAM_CKE); end
    checks++; if ({DRAM_UDQM, DRAM_LDQM} !== 2'b00) begin errors++;
      $display("FAIL reset_dqm got %b, expected 00", {DRAM_UDQM, DRAM_LDQM}); end
    checks++; if ({rowOpen, commandReady, prechargeReady, writeReady, readValid} !== 5'b01110) begin errors++;
      $display("FAIL reset_status got %b, expected 01110", {rowOpen, commandReady, prechargeReady, writeReady, readValid}); end
    checks++; if (raddr !== 25'h0 || rdata !== 16'h0) begin errors++;
      $display("FAIL reset_data got raddr=%h rdata=%h, expected 0/0", raddr, rdata); end
    checks++; if (DRAM_CLK !== 1'b1) begin errors++;
      $display("FAIL dram_clk got %b with clk low, expected 1", DRAM_CLK); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_precharge_mrs();
    int a, n;
    send(PRECHARGE_ALL, 13'h0, 2'b00, 2'b11, 16'h0, a);
    @(negedge clk);
    checks++; if (pins() !== 4'b0010 || DRAM_ADDR[10] !== 1'b1) begin errors++;
      $display("FAIL pre_pins got %b a10=%b, expected 0010 a10=1", pins(), DRAM_ADDR[10]); end
    wait_ready(n);
    checks++; if (n !== T_RP) begin errors++;
      $display("FAIL pre_busy got %0d cycles, expected %0d", n, T_RP); end
    send(SET_MODE_REG, 13'h0, 2'b00, 2'b11, 16'h0, a);
    @(negedge clk);
    checks++; if (pins() !== 4'b0000 || DRAM_ADDR !== 13'h020 || DRAM_BA !== 2'b00) begin errors++;
      $display("FAIL mrs_pins got %b addr=%h ba=%b, expected 0000 addr=020 ba=00", pins(), DRAM_ADDR, DRAM_BA); end
    wait_ready(n);
    checks++; if (n !== T_MRD) begin errors++;
      $display("FAIL mrs_busy got %0d cycles, expected %0d", n, T_MRD); end
  endtask

  task automatic test_refresh();
    int a, n;
    send(AREFRESH, 13'h0, 2'b00, 2'b11, 16'h0, a);
    command = AREFRESH;  // keep re-presenting it through the busy window
    @(negedge clk);
    checks++; if (pins() !== 4'b0001) begin errors++;
      $display("FAIL ref_pins got %b, expected 0001", pins()); end
    n = 0;
    while (!commandReady && n < 20) begin
      n++;
      @(negedge clk);
      checks++; if (pins() !== 4'b0111) begin errors++;
        $display("FAIL ref_repeat_nop got %b, expected 0111", pins()); end
    end
    command = NOOP;
    checks++; if (n !== T_RC) begin errors++;
      $display("FAIL ref_busy got %0d cycles, expected %0d", n, T_RC); end
  endtask

  task automatic test_act_write(output int a_act, output int a_wr);
    int n;
    send(ACTIVATE, 13'd5, 2'b01, 2'b11, 16'h0, a_act);
    @(negedge clk);
    checks++; if (pins() !== 4'b0011 || DRAM_BA !== 2'b01 || DRAM_ADDR !== 13'd5) begin errors++;
      $display("FAIL act_pins got %b ba=%b addr=%h, expected 0011 ba=01 addr=0005", pins(), DRAM_BA, DRAM_ADDR); end
    checks++; if (rowOpen !== 1'b1 || raddr[24:10] !== 15'h2005) begin errors++;
      $display("FAIL act_row got rowOpen=%b row=%h, expected 1 2005", rowOpen, raddr[24:10]); end
    wait_ready(n);
    checks++; if (n !== T_RCD) begin errors++;
      $display("FAIL act_busy got %0d cycles, expected %0d", n, T_RCD); end
    send(WRITE, 13'd3, 2'b00, 2'b10, 16'hDEAD, a_wr);
    written[{2'b01, 13'd5, 10'd3}] = 16'hDEAD;
    @(negedge clk);
    checks++; if (pins() !== 4'b0100 || DRAM_BA !== 2'b01 || DRAM_ADDR !== 13'd3) begin errors++;
      $display("FAIL wr_pins got %b ba=%b addr=%h, expected 0100 ba=01 addr=0003", pins(), DRAM_BA, DRAM_ADDR); end
    checks++; if (DRAM_DQ !== 16'hDEAD || DRAM_UDQM !== 1'b0 || DRAM_LDQM !== 1'b1) begin errors++;
      $display("FAIL wr_data got dq=%h udqm=%b ldqm=%b, expected DEAD 0 1", DRAM_DQ, DRAM_UDQM, DRAM_LDQM); end
  endtask

  task automatic test_precharge_wait(input int a_act, input int a_wr);
    int n, a_pre, exp_pre;
    // Earliest legal accept: T_RAS edges after ACTIVATE and T_DPL edges after WRITE.
    exp_pre = (a_act + T_RAS > a_wr + T_DPL) ? a_act + T_RAS : a_wr + T_DPL;
    command = PRECHARGE_ALL;
    n = 0;
    while (!prechargeReady && n < 20) begin
      n++;
      @(negedge clk);
      checks++; if (pins() !== 4'b0111) begin errors++;
        $display("FAIL pre_suppressed got %b, expected 0111", pins()); end
    end
    tick();
    a_pre = cyc;
    command = NOOP;
    checks++; if (a_pre !== exp_pre) begin errors++;
      $display("FAIL pre_accept_edge got %0d, expected %0d", a_pre, exp_pre); end
    @(negedge clk);
    checks++; if (pins() !== 4'b0010 || rowOpen !== 1'b0) begin errors++;
      $display("FAIL pre_after_wait got %b rowOpen=%b, expected 0010 0", pins(), rowOpen); end
    wait_ready(n);
  endtask

  task automatic test_read();
    int a, n;
    send(ACTIVATE, 13'd5, 2'b01, 2'b11, 16'h0, a);
    @(negedge clk);
    wait_ready(n);
    send(READ, 13'd3, 2'b00, 2'b11, 16'h0, a);
    expect_read({2'b01, 13'd5, 10'd3}, a);
    command = WRITE; addr = 13'd7; writeMask = 2'b11; wdata = 16'hBEEF;
    @(negedge clk);
    checks++; if (pins() !== 4'b0101 || DRAM_BA !== 2'b01 || DRAM_ADDR !== 13'd3) begin errors++;
      $display("FAIL rd_pins got %b ba=%b addr=%h, expected 0101 ba=01 addr=0003", pins(), DRAM_BA, DRAM_ADDR); end
    n = 0;
    while (!writeReady && n < 20) begin
      n++;
      @(negedge clk);
      checks++; if (pins() !== 4'b0111) begin errors++;
        $display("FAIL wr_turnaround_nop got %b, expected 0111", pins()); end
    end
    command = NOOP;
    checks++; if (n !== CL + 1) begin errors++;
      $display("FAIL turnaround got %0d cycles, expected %0d", n, CL + 1); end
    // Write a second word, then two back-to-back reads, the second closing the row.
    send(WRITE, 13'd7, 2'b00, 2'b11, 16'hBEEF, a);
    written[{2'b01, 13'd5, 10'd7}] = 16'hBEEF;
    send(READ, 13'd3, 2'b00, 2'b11, 16'h0, a);
    expect_read({2'b01, 13'd5, 10'd3}, a);
    send(READA, 13'd7, 2'b00, 2'b11, 16'h0, a);
    expect_read({2'b01, 13'd5, 10'd7}, a);
    @(negedge clk);
    checks++; if (pins() !== 4'b0101 || DRAM_ADDR !== 13'h407 || rowOpen !== 1'b0) begin errors++;
      $display("FAIL reada_pins got %b addr=%h rowOpen=%b, expected 0101 407 0", pins(), DRAM_ADDR, rowOpen); end
    wait_ready(n);
    checks++; if (n !== T_RP + 1) begin errors++;
      $display("FAIL reada_busy got %0d cycles, expected %0d", n, T_RP + 1); end
    repeat (2) @(negedge clk);
    checks++; if (sbq.size() != 0) begin errors++;
      $display("FAIL read_drain got %0d pending, expected 0", sbq.size()); end
  endtask

  task automatic test_illegal();
    int a, n;
    send(READ, 13'd2, 2'b00, 2'b11, 16'h0, a);
    @(negedge clk);
    checks++; if (pins() !== 4'b0111 || rowOpen !== 1'b0 || raddr !== {2'b01, 13'd5, 10'd7}) begin errors++;
      $display("FAIL read_closed got %b rowOpen=%b raddr=%h, expected 0111 0 %h", pins(), rowOpen, raddr, {2'b01, 13'd5, 10'd7}); end
    send(ACTIVATE, 13'd9, 2'b10, 2'b11, 16'h0, a);
    @(negedge clk);
    wait_ready(n);
    send(ACTIVATE, 13'd1, 2'b11, 2'b11, 16'h0, a);
    @(negedge clk);
    checks++; if (pins() !== 4'b0111 || rowOpen !== 1'b1 || raddr[24:10] !== {2'b10, 13'd9}) begin errors++;
      $display("FAIL act_open got %b rowOpen=%b row=%h, expected 0111 1 %h", pins(), rowOpen, raddr[24:10], {2'b10, 13'd9}); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int a;
    send(READ, 13'd4, 2'b00, 2'b11, 16'h0, a);  // in flight when reset hits; must be dropped
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (pins() !== 4'b0111 || rowOpen !== 1'b0 || raddr !== 25'h0 || commandReady !== 1'b1) begin errors++;
      $display("FAIL mid_reset got %b rowOpen=%b raddr=%h rdy=%b, expected 0111 0 0 1", pins(), rowOpen, raddr, commandReady); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (sbq.size() != 0) begin errors++;
      $display("FAIL final_queue got %0d pending, expected 0", sbq.size()); end
  endtask

  initial begin
    int a_act, a_wr;
    test_reset();
    test_precharge_mrs();
    test_refresh();
    test_act_write(a_act, a_wr);
    test_precharge_wait(a_act, a_wr);
    test_read();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
